// File: rtl/rkv_slave_responder.sv
// -----------------------------------------------------------------------------
// rkv_slave_responder
//
// Memory-backed slave endpoint for the rkv master/slave system interface.
// It accepts one read or write request at a time on a valid/ready request
// channel and decodes it against SLAVE_ID. After WAIT_CYCLES wait states it
// performs the storage access and returns a response on a valid/ready
// response channel.
//
// Optional build macro:
//   RKV_SLAVE_ID_REG_EN - word DEPTH-1 becomes a read-only ID register.
//                         Reads return {0, SLAVE_ID}; writes get SLVERR.
//                         When undefined, word DEPTH-1 is ordinary storage.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   req_valid  in   request valid
//   req_ready  out  request ready (high only in IDLE)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   byte address; top 4 bits select the slave
//   req_wdata  in   write data
//   rsp_valid  out  response valid
//   rsp_ready  in   response ready
//   rsp_rdata  out  read data (0 on writes and errors)
//   rsp_err    out  00 OKAY, 01 SLVERR, 10 DECERR
// -----------------------------------------------------------------------------
module rkv_slave_responder #(
  parameter int SLAVE_ID    = 0,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ERR_OKAY = 2'b00;
  localparam logic [1:0] ERR_SLV  = 2'b01;
  localparam logic [1:0] ERR_DEC  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_err;

  logic                w_acc_write;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic [IDX_W-1:0]    w_idx;
  logic [ADDR_W-5:0]   w_offset;
  logic                w_id_hit;
  logic [1:0]          w_err;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_do_access;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // With zero wait states the access happens on the accepting edge itself,
  // so the decode must look at the live request rather than the capture regs.
  assign w_acc_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_idx    = w_acc_addr[IDX_W+1:2];
  assign w_id_hit = (w_acc_addr[ADDR_W-1 -: 4] == 4'(SLAVE_ID));
  // Bits between the word index and the id field; a shift keeps this legal
  // even when that field is empty for small ADDR_W / large DEPTH.
  assign w_offset = w_acc_addr[ADDR_W-5:0] >> (IDX_W + 2);

  assign w_do_access = ((r_state == S_IDLE) && req_valid && r_req_ready &&
                        (WAIT_CYCLES == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // Decode priority: DECERR, then alignment, then ID register protection.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_err = ERR_OKAY;
    if (!w_id_hit || (w_offset != '0)) begin
      w_err = ERR_DEC;
    end else if (w_acc_addr[1:0] != 2'b00) begin
      w_err = ERR_SLV;
`ifdef RKV_SLAVE_ID_REG_EN
    end else if ((w_idx == IDX_W'(DEPTH - 1)) && w_acc_write) begin
      w_err = ERR_SLV;
`endif
    end
  end

  always_comb begin
    w_rdata = '0;
    if ((w_err == ERR_OKAY) && !w_acc_write) begin
`ifdef RKV_SLAVE_ID_REG_EN
      if (w_idx == IDX_W'(DEPTH - 1)) begin
        w_rdata = {{(DATA_W-4){1'b0}}, 4'(SLAVE_ID)};
      end else begin
        w_rdata = r_mem[w_idx];
      end
`else
      w_rdata = r_mem[w_idx];
`endif
    end
  end

  // NOTE: storage sits in the reset domain because a reset must clear every
  // word; that rules out a plain RAM macro for this array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OKAY;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_cnt       <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Payload registers are untouched here, so they hold under backpressure.
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase

      if (w_do_access) begin
        r_rsp_rdata <= w_rdata;
        r_rsp_err   <= w_err;
        if ((w_err == ERR_OKAY) && w_acc_write) begin
          r_mem[w_idx] <= w_acc_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_rkv_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_rkv_slave_responder
//
// Four responder instances share one clock and reset:
//   0: SLAVE_ID 0, WAIT_CYCLES 2
//   1: SLAVE_ID 1, WAIT_CYCLES 2
//   2: SLAVE_ID 0, WAIT_CYCLES 0
//   3: SLAVE_ID 3, WAIT_CYCLES 2 (ID register word when the macro is on)
// A table of directed single transactions is applied first, followed by
// hand-written backpressure, throughput and mid-transaction reset sequences.
// -----------------------------------------------------------------------------
module tb_rkv_slave_responder;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [15:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic [1:0]  rsp_err   [N];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rkv_slave_responder #(
      .SLAVE_ID   ((g == 1) ? 1 : (g == 3) ? 3 : 0),
      .ADDR_W     (16),
      .DATA_W     (32),
      .DEPTH      (16),
      .WAIT_CYCLES((g == 2) ? 0 : 2)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          d;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input bit wr, input logic [15:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic [1:0] exp_err);
    vec_t v;
    v.d         = d;
    v.wr        = wr;
    v.addr      = addr;
    v.wdata     = wdata;
    v.exp_rdata = exp_rdata;
    v.exp_err   = exp_err;
    v.exp_lat   = (d == 2) ? 1 : 3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; lat counts cycles from the handshake cycle to the
  // first cycle with rsp_valid high (1 + WAIT_CYCLES when correct).
  task automatic do_txn(input int d, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [1:0] er, output int lat);
    int guard;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      tick();
      guard++;
    end
    if (!req_ready[d]) check($sformatf("dut%0d req_ready timeout", d), 32'(req_ready[d]), 32'd1);
    tick();
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin
      tick();
      lat++;
    end
    if (!rsp_valid[d]) check($sformatf("dut%0d rsp_valid timeout", d), 32'(rsp_valid[d]), 32'd1);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    int          n_hs;
    int          n_rsp;
    int          guard;

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b0;
    end

    vecs.push_back(mk(0, 1, 16'h0008, 32'hDEADBEEF, 32'h0,        2'b00));
    vecs.push_back(mk(0, 0, 16'h0008, 32'h0,        32'hDEADBEEF, 2'b00));
    vecs.push_back(mk(1, 1, 16'h0004, 32'h01020304, 32'h0,        2'b10));
    vecs.push_back(mk(1, 1, 16'h1100, 32'h05060708, 32'h0,        2'b10));
    vecs.push_back(mk(1, 1, 16'h1006, 32'hAAAA5555, 32'h0,        2'b01));
    vecs.push_back(mk(1, 0, 16'h1004, 32'h0,        32'h0,        2'b00));
    vecs.push_back(mk(1, 1, 16'h1004, 32'hCAFEF00D, 32'h0,        2'b00));
    vecs.push_back(mk(1, 0, 16'h1004, 32'h0,        32'hCAFEF00D, 2'b00));
    vecs.push_back(mk(1, 0, 16'h1006, 32'h0,        32'h0,        2'b01));
    vecs.push_back(mk(1, 0, 16'h0000, 32'h0,        32'h0,        2'b10));
    vecs.push_back(mk(2, 1, 16'h0038, 32'h11223344, 32'h0,        2'b00));
    vecs.push_back(mk(2, 0, 16'h0038, 32'h0,        32'h11223344, 2'b00));
    vecs.push_back(mk(0, 0, 16'h0040, 32'h0,        32'h0,        2'b10));
    vecs.push_back(mk(0, 0, 16'h003C, 32'h0,        32'h0,        2'b00));
`ifdef RKV_SLAVE_ID_REG_EN
    vecs.push_back(mk(3, 0, 16'h303C, 32'h0,        32'h00000003, 2'b00));
    vecs.push_back(mk(3, 1, 16'h303C, 32'h00000055, 32'h0,        2'b01));
    vecs.push_back(mk(3, 0, 16'h303C, 32'h0,        32'h00000003, 2'b00));
`else
    vecs.push_back(mk(3, 0, 16'h303C, 32'h0,        32'h0,        2'b00));
    vecs.push_back(mk(3, 1, 16'h303C, 32'h00000055, 32'h0,        2'b00));
    vecs.push_back(mk(3, 0, 16'h303C, 32'h0,        32'h00000055, 2'b00));
`endif

    // Reset values
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      check($sformatf("dut%0d reset req_ready", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("dut%0d reset rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("dut%0d reset rsp_rdata", i), rsp_rdata[i], 32'd0);
      check($sformatf("dut%0d reset rsp_err", i),   32'(rsp_err[i]), 32'd0);
    end

    // Directed transaction table
    for (int v = 0; v < vecs.size(); v++) begin
      do_txn(vecs[v].d, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, er, lat);
      check($sformatf("vec%0d rdata", v),   rd,          vecs[v].exp_rdata);
      check($sformatf("vec%0d err", v),     32'(er),     32'(vecs[v].exp_err));
      check($sformatf("vec%0d latency", v), 32'(lat),    32'(vecs[v].exp_lat));
      check($sformatf("vec%0d req_ready after rsp", v), 32'(req_ready[vecs[v].d]), 32'd1);
    end

    // Backpressure on dut0: hold rsp_ready low for 5 cycles while a second
    // request is offered; it must not be accepted.
    req_write[0] = 1'b0;
    req_addr[0]  = 16'h0008;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    guard = 0;
    while (!rsp_valid[0] && guard < 50) begin
      tick();
      guard++;
    end
    check("bp rsp_valid rise cycles", 32'(guard), 32'd2);
    req_write[0] = 1'b1;
    req_wdata[0] = 32'hBAD0BAD0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp%0d rsp_rdata", i), rsp_rdata[0], 32'hDEADBEEF);
      check($sformatf("bp%0d rsp_err", i),   32'(rsp_err[0]), 32'd0);
      check($sformatf("bp%0d req_ready", i), 32'(req_ready[0]), 32'd0);
      tick();
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    check("bp req_ready after handshake", 32'(req_ready[0]), 32'd1);
    check("bp rsp_valid after handshake", 32'(rsp_valid[0]), 32'd0);
    do_txn(0, 1'b0, 16'h0008, 32'h0, rd, er, lat);
    check("bp reread rdata", rd, 32'hDEADBEEF);

    // Zero wait states: continuous traffic accepts one request every 2 cycles.
    req_write[2] = 1'b1;
    req_addr[2]  = 16'h0010;
    req_wdata[2] = 32'h0BADCAFE;
    req_valid[2] = 1'b1;
    rsp_ready[2] = 1'b1;
    n_hs  = 0;
    n_rsp = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid[2] && req_ready[2]) n_hs++;
      if (rsp_valid[2] && rsp_ready[2]) n_rsp++;
      tick();
    end
    req_valid[2] = 1'b0;
    rsp_ready[2] = 1'b0;
    check("b2b request handshakes in 10 cycles", 32'(n_hs), 32'd5);
    check("b2b response handshakes in 10 cycles", 32'(n_rsp), 32'd5);
    do_txn(2, 1'b0, 16'h0010, 32'h0, rd, er, lat);
    check("b2b reread rdata", rd, 32'h0BADCAFE);
    check("b2b reread latency", 32'(lat), 32'd1);

    // Reset during WAIT of a write to 0x0000
    req_write[0] = 1'b1;
    req_addr[0]  = 16'h0000;
    req_wdata[0] = 32'h12345678;
    req_valid[0] = 1'b1;
    check("rst-mid req_ready before", 32'(req_ready[0]), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    check("rst-mid in WAIT req_ready", 32'(req_ready[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst-mid async req_ready", 32'(req_ready[0]), 32'd1);
    check("rst-mid async rsp_valid", 32'(rsp_valid[0]), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    n_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid[0]) n_rsp++;
      tick();
    end
    check("rst-mid no response after reset", 32'(n_rsp), 32'd0);
    do_txn(0, 1'b0, 16'h0000, 32'h0, rd, er, lat);
    check("rst-mid read 0x0000 rdata", rd, 32'h0);
    check("rst-mid read 0x0000 err", 32'(er), 32'd0);
    do_txn(0, 1'b0, 16'h0008, 32'h0, rd, er, lat);
    check("rst-mid storage cleared 0x0008", rd, 32'h0);
    do_txn(1, 1'b0, 16'h1004, 32'h0, rd, er, lat);
    check("rst-mid storage cleared 0x1004", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
